// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with overlap control and a
// saturating match counter; the match pulse is registered.
module seq_det_prog #(
    parameter int                 SEQ_LEN     = 4,
    parameter logic [SEQ_LEN-1:0] DEFAULT_PAT = 4'b0101,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               in_valid,
    input  logic [SEQ_LEN-1:0] pattern,
    input  logic               pat_load,
    input  logic               overlap_en,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int HW = SEQ_LEN - 1;
    localparam int FW = $clog2(SEQ_LEN + 1);
    localparam logic [FW-1:0] FULL    = FW'(SEQ_LEN);
    localparam logic [FW-1:0] ARM_PRE = FW'(SEQ_LEN - 2);

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [HW-1:0]      hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [SEQ_LEN-1:0] pat_q, pat_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               match;
    logic [SEQ_LEN-1:0] window;

    // A load cycle discards the bit presented with it
    assign accept = in_valid & ~pat_load;
    assign window = {hist_q, x};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILLING;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pat_load) begin
            state_d = FILLING;
        end else if (accept) begin
            unique case (state_q)
                FILLING: if (fill_q >= ARM_PRE) state_d = ARMED;
                ARMED:   if (match && !overlap_en) state_d = FILLING;
                default: state_d = FILLING;
            endcase
        end
    end

    always_comb begin
        match = (state_q == ARMED) && accept && (window == pat_q);
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        out_d  = match;
        cnt_d  = cnt_q;
        if (pat_load) begin
            pat_d  = pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = window[HW-1:0];
            if (match && !overlap_en) begin
                fill_d = '0;
            end else if (fill_q != FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
        // Clear beats a simultaneous match
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEFAULT_PAT;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;

endmodule
